sram_dma_wr_ctrl: RTL and testbench

DMA write engine, the write-direction counterpart of the ROM/SRAM read DMA. Pops words from an upstream show-ahead FIFO and writes them to an external asynchronous parallel memory (CE_bar/OE_bar/WE_bar) at consecutive addresses from a configured base. Programmable setup, write-pulse and hold phases. Pulses batch_dma_done when the configured word count has been written.

---
 rtl/sram_dma_wr_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_sram_dma_wr_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dma_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_dma_wr_ctrl
//  Function : DMA write engine. Pops words from a show-ahead FIFO and writes
//             them to an asynchronous parallel memory (CE_bar/OE_bar/WE_bar)
//             at consecutive addresses, with programmable setup, write-pulse
//             and hold phases. Pulses batch_dma_done after the last word.
//  Options  : define SRAM_WR_VERIFY_EN to add a readback VERIFY phase after
//             every word; a mismatch sets the sticky verify_err flag.
//  Revision : 1.0  initial release
// ============================================================================
module sram_dma_wr_ctrl #(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYC    = 1,
  parameter int WR_PULSE_CYC = 3,
  parameter int HOLD_CYC     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_data_pop,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_oe,
  output logic                  CE_bar,
  output logic                  OE_bar,
  output logic                  WE_bar,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  start_wr,
  input  logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_dma_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_dma_num_words,
  output logic                  busy,
  output logic                  batch_dma_done,
  output logic                  verify_err
);

  // Phase counter is sized from the longest programmable phase.
  localparam int MAX_AB = (SETUP_CYC > WR_PULSE_CYC) ? SETUP_CYC : WR_PULSE_CYC;
  localparam int MAX_PH = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CNT_W  = $clog2(MAX_PH) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_WE     = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_VERIFY = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic [CNT_W-1:0]      ph_cnt;
  logic                  ph_last;
  logic                  start_prev;
  logic                  start_pending;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] word_cnt_inc;

  // Next values of the registered memory-side outputs.
  logic ce_n_nx;
  logic oe_n_nx;
  logic we_n_nx;
  logic doe_nx;
  logic done_nx;

  assign busy          = (state != S_IDLE);
  assign fifo_data_pop = (state == S_FETCH) && !fifo_empty;
  assign accept        = (state == S_IDLE) && start_pending && cfg_ready;
  assign word_cnt_inc  = word_cnt + ADDR_WIDTH'(1);

  // Detect the last cycle of the current timed phase.
  always_comb begin
    ph_last = 1'b0;
    case (state)
      S_SETUP:  ph_last = (ph_cnt == CNT_W'(SETUP_CYC - 1));
      S_WE:     ph_last = (ph_cnt == CNT_W'(WR_PULSE_CYC - 1));
      S_HOLD:   ph_last = (ph_cnt == CNT_W'(HOLD_CYC - 1));
      S_VERIFY: ph_last = (ph_cnt == CNT_W'(SETUP_CYC));
      default:  ph_last = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (cfg_dma_num_words == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) state_next = S_SETUP;
      end
      S_SETUP: begin
        if (ph_last) state_next = S_WE;
      end
      S_WE: begin
        if (ph_last) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (ph_last) begin
`ifdef SRAM_WR_VERIFY_EN
          state_next = S_VERIFY;
`else
          state_next = (word_cnt_inc == num_q) ? S_DONE : S_FETCH;
`endif
        end
      end
      S_VERIFY: begin
        // word_cnt was already advanced on the last HOLD cycle
        if (ph_last) state_next = (word_cnt == num_q) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered pins line up with the state.
  always_comb begin
    ce_n_nx = 1'b1;
    oe_n_nx = 1'b1;
    we_n_nx = 1'b1;
    doe_nx  = 1'b0;
    done_nx = 1'b0;
    case (state_next)
      S_SETUP, S_HOLD: begin
        ce_n_nx = 1'b0;
        doe_nx  = 1'b1;
      end
      S_WE: begin
        ce_n_nx = 1'b0;
        we_n_nx = 1'b0;
        doe_nx  = 1'b1;
      end
      S_VERIFY: begin
        ce_n_nx = 1'b0;
        oe_n_nx = 1'b0;
      end
      S_DONE:  done_nx = 1'b1;
      default: ;
    endcase
  end

  // Registered memory strobes and completion pulse (glitch-free pins).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      CE_bar         <= 1'b1;
      OE_bar         <= 1'b1;
      WE_bar         <= 1'b1;
      wr_data_oe     <= 1'b0;
      batch_dma_done <= 1'b0;
    end else begin
      CE_bar         <= ce_n_nx;
      OE_bar         <= oe_n_nx;
      WE_bar         <= we_n_nx;
      wr_data_oe     <= doe_nx;
      batch_dma_done <= done_nx;
    end
  end

  // Phase cycle counter, restarted on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_cnt <= '0;
    end else if (state_next != state) begin
      ph_cnt <= '0;
    end else begin
      ph_cnt <= ph_cnt + CNT_W'(1);
    end
  end

  // Start edge detection; edges seen while busy are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev    <= 1'b0;
      start_pending <= 1'b0;
    end else begin
      start_prev <= start_wr;
      if (state == S_DONE) begin
        start_pending <= 1'b0;
      end else if (start_wr && !start_prev && !busy) begin
        start_pending <= 1'b1;
      end
    end
  end

  // Job configuration, word counter, address and data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      num_q    <= '0;
      word_cnt <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (accept) begin
        base_q   <= cfg_dma_base_addr;
        num_q    <= cfg_dma_num_words;
        word_cnt <= '0;
      end
      if (fifo_data_pop) begin
        wr_addr <= base_q + word_cnt;   // wraps modulo 2^ADDR_WIDTH
        wr_data <= fifo_data_out;
      end
      if (state == S_HOLD && ph_last) begin
        word_cnt <= word_cnt_inc;
      end
    end
  end

`ifdef SRAM_WR_VERIFY_EN
  // Sticky readback comparison, sampled on the last VERIFY cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      verify_err <= 1'b0;
    end else if (accept) begin
      verify_err <= 1'b0;
    end else if (state == S_VERIFY && ph_last && (rd_data != wr_data)) begin
      verify_err <= 1'b1;
    end
  end
`else
  // Readback is not built; the read bus is intentionally left unobserved.
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign verify_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_dma_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_dma_wr_ctrl
//  Function : Directed self-checking bench for sram_dma_wr_ctrl with a small
//             show-ahead FIFO model and a write-strobe monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_dma_wr_ctrl;

`ifdef SRAM_WR_VERIFY_EN
  localparam int WORD_LAT = 8;
`else
  localparam int WORD_LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  fifo_data_out;
  logic        fifo_empty;
  logic        fifo_data_pop;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_data_oe;
  logic        CE_bar;
  logic        OE_bar;
  logic        WE_bar;
  logic [7:0]  rd_data;
  logic        start_wr = 1'b0;
  logic        cfg_ready = 1'b1;
  logic [19:0] cfg_dma_base_addr = '0;
  logic [19:0] cfg_dma_num_words = '0;
  logic        busy;
  logic        batch_dma_done;
  logic        verify_err;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model: initial block owns wp, monitor owns rp.
  logic [7:0] fmem [0:15];
  int wp = 0;
  int rp = 0;
  assign fifo_empty    = (wp == rp);
  assign fifo_data_out = fmem[rp[3:0]];

  // Memory readback model, optionally corrupted while a chosen word is active.
  int corrupt_at = -1;
  int wcount = 0;
  assign rd_data = (wcount == corrupt_at) ? ~wr_data : wr_data;

  // Monitor counters.
  int pops = 0;
  int we_low = 0;
  int ce_low = 0;
  int proto_err = 0;
  logic        we_prev = 1'b1;
  logic [19:0] addr_log [0:15];
  logic [7:0]  data_log [0:15];

  always #5 clk = ~clk;

  sram_dma_wr_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .fifo_data_out     (fifo_data_out),
    .fifo_empty        (fifo_empty),
    .fifo_data_pop     (fifo_data_pop),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_data_oe        (wr_data_oe),
    .CE_bar            (CE_bar),
    .OE_bar            (OE_bar),
    .WE_bar            (WE_bar),
    .rd_data           (rd_data),
    .start_wr          (start_wr),
    .cfg_ready         (cfg_ready),
    .cfg_dma_base_addr (cfg_dma_base_addr),
    .cfg_dma_num_words (cfg_dma_num_words),
    .busy              (busy),
    .batch_dma_done    (batch_dma_done),
    .verify_err        (verify_err)
  );

  // FIFO read pointer advances on each pop.
  always @(posedge clk) begin
    if (fifo_data_pop) rp <= rp + 1;
  end

  // Bus monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      we_prev <= 1'b1;
    end else begin
      if (fifo_data_pop) pops <= pops + 1;
      if (!WE_bar) we_low <= we_low + 1;
      if (!CE_bar) ce_low <= ce_low + 1;
      if (!WE_bar && we_prev) begin
        addr_log[wcount[3:0]] <= wr_addr;
        data_log[wcount[3:0]] <= wr_data;
        wcount <= wcount + 1;
      end
      if (!WE_bar && (CE_bar || !wr_data_oe || !OE_bar)) proto_err <= proto_err + 1;
      if (!OE_bar && wr_data_oe) proto_err <= proto_err + 1;
      we_prev <= WE_bar;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wp[3:0]] = d;
    wp = wp + 1;
  endtask

  // Drive a start edge; returns on the falling edge after the edge is sampled.
  task automatic start_job(input logic [19:0] base, input logic [19:0] num);
    @(negedge clk);
    cfg_dma_base_addr = base;
    cfg_dma_num_words = num;
    start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
  endtask

  // Count falling edges until the done pulse is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!batch_dma_done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!batch_dma_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int w0;
    int p0;
    int wl0;
    int c0;
    int pe0;
    int k;

    // ---------------- reset state ----------------
    #12;
    check("rst_CE_bar", {31'd0, CE_bar}, 32'd1);
    check("rst_WE_bar", {31'd0, WE_bar}, 32'd1);
    check("rst_OE_bar", {31'd0, OE_bar}, 32'd1);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, batch_dma_done}, 32'd0);
    check("rst_oe",     {31'd0, wr_data_oe}, 32'd0);
    check("rst_addr",   {12'd0, wr_addr}, 32'd0);
    check("rst_verr",   {31'd0, verify_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- 4 words from 0x100 ----------------
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    w0 = wcount; p0 = pops; wl0 = we_low; pe0 = proto_err;
    start_job(20'h00100, 20'd4);
    @(negedge clk);
    cfg_dma_base_addr = 20'h55555;   // must not affect the running job
    cfg_dma_num_words = 20'd9;
    wait_done(lat);
    check("t1_latency", lat, WORD_LAT * 4);
    @(negedge clk);
    check("t1_done_width", {31'd0, batch_dma_done}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_pops",   pops - p0, 32'd4);
    check("t1_we_low", we_low - wl0, 32'd12);
    check("t1_writes", wcount - w0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      k = (w0 + i) & 15;
      check($sformatf("t1_addr%0d", i), {12'd0, addr_log[k]}, 32'h100 + i);
      check($sformatf("t1_data%0d", i), {24'd0, data_log[k]}, 32'hA0 + i);
    end
    check("t1_proto", proto_err - pe0, 32'd0);
    check("t1_verr",  {31'd0, verify_err}, 32'd0);

    // ---------------- zero-length job ----------------
    p0 = pops; c0 = ce_low;
    start_job(20'h00200, 20'd0);
    wait_done(lat);
    check("t2_latency", lat, 32'd1);
    @(negedge clk);
    check("t2_pops",   pops - p0, 32'd0);
    check("t2_ce_low", ce_low - c0, 32'd0);

    // ---------------- FIFO starved, then one word ----------------
    w0 = wcount; p0 = pops;
    start_job(20'h00020, 20'd1);
    repeat (10) @(negedge clk);
    check("t3_wait_ce",   {31'd0, CE_bar}, 32'd1);
    check("t3_wait_busy", {31'd0, busy}, 32'd1);
    check("t3_wait_pops", pops - p0, 32'd0);
    push(8'h5A);
    wait_done(lat);
    @(negedge clk);
    check("t3_writes", wcount - w0, 32'd1);
    check("t3_addr", {12'd0, addr_log[w0 & 15]}, 32'h20);
    check("t3_data", {24'd0, data_log[w0 & 15]}, 32'h5A);

    // ---------------- address wrap ----------------
    w0 = wcount;
    push(8'h11); push(8'h22);
    start_job(20'hFFFFF, 20'd2);
    wait_done(lat);
    check("t4_latency", lat, WORD_LAT * 2 + 1);
    @(negedge clk);
    check("t4_addr0", {12'd0, addr_log[w0 & 15]}, 32'hFFFFF);
    check("t4_addr1", {12'd0, addr_log[(w0 + 1) & 15]}, 32'h00000);
    check("t4_data1", {24'd0, data_log[(w0 + 1) & 15]}, 32'h22);

    // ---------------- reset in the middle of the write pulse ----------------
    push(8'h33); push(8'h44);
    start_job(20'h00300, 20'd2);
    k = 0;
    while (WE_bar && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_we_seen", {31'd0, WE_bar}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_we",   {31'd0, WE_bar}, 32'd1);
    check("t5_rst_ce",   {31'd0, CE_bar}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    wp = rp;                          // discard the leftover word
    reset_n = 1'b1;
    @(negedge clk);
    w0 = wcount;
    push(8'h77);
    start_job(20'h00040, 20'd1);
    wait_done(lat);
    check("t5_latency", lat, WORD_LAT + 1);
    @(negedge clk);
    check("t5_addr", {12'd0, addr_log[w0 & 15]}, 32'h40);
    check("t5_data", {24'd0, data_log[w0 & 15]}, 32'h77);

`ifdef SRAM_WR_VERIFY_EN
    // ---------------- readback mismatch on word 1 ----------------
    push(8'hC0); push(8'hC1); push(8'hC2);
    corrupt_at = wcount + 2;
    start_job(20'h00400, 20'd3);
    wait_done(lat);
    check("t6_latency", lat, WORD_LAT * 3 + 1);
    check("t6_verr_done", {31'd0, verify_err}, 32'd1);
    repeat (3) @(negedge clk);
    check("t6_verr_sticky", {31'd0, verify_err}, 32'd1);
    corrupt_at = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog in case a wait is never satisfied.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
